// File: rtl/bcd_pkg.sv
// Shared BCD constants and nibble helpers for the up/down counter slice.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    function automatic logic bcd_valid(input logic [3:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decade of the counter: synchronous clear, load with invalid-nibble
// scrubbing, and wrap-around increment/decrement driven by the top-level chain.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       inc,
    input  logic       dec,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       is9,
    output logic       is0
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (rst) begin
            q_d = BCD_MIN;
        end else if (load) begin
            q_d = bcd_valid(d) ? d : BCD_MIN;
        end else if (inc) begin
            q_d = (q_q >= BCD_MAX) ? BCD_MIN : q_q + 4'd1;
        end else if (dec) begin
            // Values above 9 cannot arise, but are folded to 9 rather than trusted.
            q_d = (q_q == BCD_MIN || !bcd_valid(q_q)) ? BCD_MAX : q_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q   = q_q;
    assign is9 = (q_q == BCD_MAX);
    assign is0 = (q_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter_n.sv
// N-digit synchronous BCD up/down counter with wrap/saturate ends,
// cascade terminal-count outputs and invalid-load flag.
module bcd_updown_counter_n
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 2,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  CP,
    input  logic                  MR_n,
    input  logic                  CE,
    input  logic                  UP,
    input  logic                  PL_n,
    input  logic [4*DIGITS-1:0]   P,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  TCu_n,
    output logic                  TCd_n,
    output logic                  LDERR
);

    logic              rst;
    logic              load;
    logic              all9;
    logic              all0;
    logic              up_step;
    logic              dn_step;
    logic [DIGITS-1:0] inc;
    logic [DIGITS-1:0] dec;
    logic [DIGITS-1:0] is9;
    logic [DIGITS-1:0] is0;
    logic              lderr_q;
    logic              lderr_d;

    assign rst  = ~MR_n;
    assign load = ~PL_n;
    assign all9 = &is9;
    assign all0 = &is0;

    // In saturate mode the range end suppresses the step at the chain root.
    assign up_step = CE &  UP & (WRAP | ~all9);
    assign dn_step = CE & ~UP & (WRAP | ~all0);

    always_comb begin
        inc    = '0;
        dec    = '0;
        inc[0] = up_step;
        dec[0] = dn_step;
        for (int unsigned k = 1; k < DIGITS; k++) begin
            inc[k] = inc[k-1] & is9[k-1];
            dec[k] = dec[k-1] & is0[k-1];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk  (CP),
            .rst  (rst),
            .load (load),
            .inc  (inc[g]),
            .dec  (dec[g]),
            .d    (P[4*g +: 4]),
            .q    (Q[4*g +: 4]),
            .is9  (is9[g]),
            .is0  (is0[g])
        );
    end

    always_comb begin
        lderr_d = lderr_q;
        if (rst) begin
            lderr_d = 1'b0;
        end else if (load) begin
            lderr_d = 1'b0;
            for (int unsigned k = 0; k < DIGITS; k++) begin
                if (!bcd_valid(P[4*k +: 4])) begin
                    lderr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CP) begin
        lderr_q <= lderr_d;
    end

    assign LDERR = lderr_q;
    assign TCu_n = ~(MR_n & CE & UP & all9);
    assign TCd_n = ~(CE & ~UP & all0);

endmodule
